// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Latches the execute-stage payload, waits for the data-SRAM response of
// loads/stores, aligns load data (including lwl/lwr lane enables) and hands
// the result to write-back. A flush from write-back drops any response that
// is still in flight for the killed instruction.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [124:0] es_to_ms_bus,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [85:0]  ms_to_ws_bus,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata,
    output logic [9:0]   stall_ms_bus,
    output logic [32:0]  forward_ms_bus
);

    logic         ms_valid_r;
    logic [124:0] es_to_ms_bus_r;
    logic         buf_valid_r;
    logic [31:0]  buf_data_r;
    logic         cancel_r;

    logic [4:0]  ctrl_s;          // bd, exc_sys, eret, cp0_wen, res_from_cp0
    logic [7:0]  cp0_addr_s;
    logic        mem_req_s;
    logic        load_op_s;
    logic [2:0]  load_type_s;
    logic [1:0]  addr_low_s;
    logic [3:0]  bus_gr_we_s;
    logic [4:0]  dest_s;
    logic [31:0] alu_result_s;
    logic [31:0] pc_s;
    logic        unused_bits_s;

    logic        ms_ready_go_s;
    logic [31:0] ld_s;
    logic [31:0] final_result_s;
    logic [3:0]  gr_we_s;
    logic        buf_capture_s;
    logic        cancel_set_s;

    assign ctrl_s        = es_to_ms_bus_r[124:120];
    assign cp0_addr_s    = es_to_ms_bus_r[119:112];
    assign mem_req_s     = es_to_ms_bus_r[111];
    assign load_op_s     = es_to_ms_bus_r[110];
    assign load_type_s   = es_to_ms_bus_r[109:107];
    assign addr_low_s    = es_to_ms_bus_r[106:105];
    assign unused_bits_s = ^es_to_ms_bus_r[104:73];
    assign bus_gr_we_s   = es_to_ms_bus_r[72:69];
    assign dest_s        = es_to_ms_bus_r[68:64];
    assign alu_result_s  = es_to_ms_bus_r[63:32];
    assign pc_s          = es_to_ms_bus_r[31:0];

    // Align the loaded word for each load flavour; byte lane chosen by addr_low.
    function automatic logic [31:0] load_result(input logic [2:0]  lt,
                                                input logic [1:0]  a,
                                                input logic [31:0] ld);
        logic [31:0] shr;
        logic [7:0]  b;
        logic [15:0] h;
        shr = ld >> {a, 3'b000};
        b   = shr[7:0];
        h   = a[1] ? ld[31:16] : ld[15:0];
        case (lt)
            3'd0:    load_result = ld;
            3'd1:    load_result = {{24{b[7]}}, b};
            3'd2:    load_result = {24'h000000, b};
            3'd3:    load_result = {{16{h[15]}}, h};
            3'd4:    load_result = {16'h0000, h};
            3'd5:    load_result = ld << {~a, 3'b000};
            3'd6:    load_result = shr;
            default: load_result = ld;
        endcase
    endfunction

    // Register-file byte-lane enables; only lwl/lwr write partial words.
    function automatic logic [3:0] load_gr_we(input logic [2:0] lt,
                                              input logic [1:0] a);
        case (lt)
            3'd5: begin
                case (a)
                    2'd0:    load_gr_we = 4'b1000;
                    2'd1:    load_gr_we = 4'b1100;
                    2'd2:    load_gr_we = 4'b1110;
                    default: load_gr_we = 4'b1111;
                endcase
            end
            3'd6: begin
                case (a)
                    2'd0:    load_gr_we = 4'b1111;
                    2'd1:    load_gr_we = 4'b0111;
                    2'd2:    load_gr_we = 4'b0011;
                    default: load_gr_we = 4'b0001;
                endcase
            end
            default: load_gr_we = 4'b1111;
        endcase
    endfunction

    assign ms_ready_go_s  = !mem_req_s || (data_data_ok && !cancel_r) || buf_valid_r;
    assign ms_allowin     = !ms_valid_r || (ms_ready_go_s && ws_allowin);
    assign ms_to_ws_valid = ms_valid_r && ms_ready_go_s;
    assign ld_s           = buf_valid_r ? buf_data_r : data_rdata;

    // Capture a live response when WB is not ready, so it survives the stall.
    assign buf_capture_s = data_data_ok && !cancel_r && ms_valid_r && mem_req_s
                           && !buf_valid_r && !ws_allowin;

    // On flush, remember a response still owed to a killed instruction: either
    // the one waiting in MS or the ES one whose request already went out.
    // A response consumed this cycle (including a cancelled one) is not owed.
    assign cancel_set_s = (ms_valid_r && mem_req_s && !buf_valid_r
                           && !(data_data_ok && !cancel_r))
                          || (es_to_ms_valid && ms_allowin && es_to_ms_bus[111])
                          || (cancel_r && !data_data_ok);

    // Result and lane-enable selection for loads, stores and ALU ops.
    always_comb begin
        final_result_s = alu_result_s;
        gr_we_s        = bus_gr_we_s;
        if (load_op_s) begin
            final_result_s = load_result(load_type_s, addr_low_s, ld_s);
            gr_we_s        = load_gr_we(load_type_s, addr_low_s);
        end else if (mem_req_s) begin
            final_result_s = alu_result_s;
            gr_we_s        = 4'b0000;
        end else begin
            final_result_s = alu_result_s;
            gr_we_s        = bus_gr_we_s;
        end
    end

    assign ms_to_ws_bus   = {ctrl_s, cp0_addr_s, gr_we_s, dest_s, final_result_s, pc_s};
    assign stall_ms_bus   = {ms_valid_r && (|gr_we_s), gr_we_s & {4{ms_valid_r}}, dest_s};
    assign forward_ms_bus = {ms_valid_r && ms_ready_go_s, final_result_s};

    // Stage valid, response buffer flag and cancel tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_r  <= 1'b0;
            buf_valid_r <= 1'b0;
            cancel_r    <= 1'b0;
        end else if (flush) begin
            ms_valid_r  <= 1'b0;
            buf_valid_r <= 1'b0;
            cancel_r    <= cancel_set_s;
        end else begin
            if (ms_allowin) begin
                ms_valid_r <= es_to_ms_valid;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                buf_valid_r <= 1'b0;
            end else if (buf_capture_s) begin
                buf_valid_r <= 1'b1;
            end
            cancel_r <= cancel_r && !data_data_ok;
        end
    end

    // Buffered response data, held until the instruction moves to WB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_data_r <= 32'h0000_0000;
        end else if (!flush && buf_capture_s) begin
            buf_data_r <= data_rdata;
        end
    end

    // Execute-stage payload latch; a flushed cycle latches nothing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_to_ms_bus_r <= 125'd0;
        end else if (es_to_ms_valid && ms_allowin && !flush) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB payloads are queued as each
// instruction is driven and compared when the stage hands them to WB.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [124:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [85:0]  ms_to_ws_bus;
    logic         data_data_ok;
    logic [31:0]  data_rdata;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;

    logic [85:0]  exp_q[$];
    int           n_checks;
    int           n_fail;
    logic [31:0]  pc;

    mem_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .stall_ms_bus   (stall_ms_bus),
        .forward_ms_bus (forward_ms_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [124:0] es_bus(input logic [4:0] ctrl, input logic [7:0] cp0a,
                                            input logic mreq, input logic lop,
                                            input logic [2:0] lt, input logic [1:0] a,
                                            input logic [3:0] we, input logic [4:0] dst,
                                            input logic [31:0] alu, input logic [31:0] p);
        es_bus = {ctrl, cp0a, mreq, lop, lt, a, 32'hA5A5_A5A5, we, dst, alu, p};
    endfunction

    function automatic logic [85:0] ws_bus(input logic [4:0] ctrl, input logic [7:0] cp0a,
                                           input logic [3:0] we, input logic [4:0] dst,
                                           input logic [31:0] res, input logic [31:0] p);
        ws_bus = {ctrl, cp0a, we, dst, res, p};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [124:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        #1;
        chk("allowin_on_send", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
    endtask

    // One load through MS with the response arriving after 'delay' wait cycles.
    task automatic load(input string tag, input logic [2:0] lt, input logic [1:0] a,
                        input logic [31:0] rd, input logic [31:0] res,
                        input logic [3:0] we, input int delay);
        exp_q.push_back(ws_bus(5'd0, 8'd0, we, 5'd7, res, pc));
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, lt, a, 4'hF, 5'd7, 32'h0000_1000, pc));
        pc = pc + 32'd4;
        for (int i = 0; i < delay; i++) begin
            chk({tag, "_stall"}, ms_allowin, 1'b0);
            chk({tag, "_fwd_wait"}, forward_ms_bus[32], 1'b0);
            tick();
        end
        data_data_ok = 1'b1;
        data_rdata   = rd;
        #1;
        chk({tag, "_valid"}, ms_to_ws_valid, 1'b1);
        chk({tag, "_fwd"}, forward_ms_bus, {1'b1, res});
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        chk({tag, "_gone"}, ms_to_ws_valid, 1'b0);
    endtask

    // Scoreboard: every hand-off to WB must match the oldest queued payload.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexpected_retire: observed bus %0h expected none", ms_to_ws_bus);
            end else begin
                chk("retire_bus", ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        pc             = 32'hBFC0_0000;
        resetn         = 1'b0;
        flush          = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = 125'd0;
        ws_allowin     = 1'b1;
        data_data_ok   = 1'b0;
        data_rdata     = 32'h0;
        repeat (2) tick();
        resetn = 1'b1;
        #1;
        chk("rst_allowin", ms_allowin, 1'b1);
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_stall_v", stall_ms_bus[9], 1'b0);
        chk("rst_fwd_v", forward_ms_bus[32], 1'b0);

        // ALU op: leaves one cycle after entry, control fields pass through.
        exp_q.push_back(ws_bus(5'b10010, 8'h0C, 4'hF, 5'd3, 32'h1234_5678, pc));
        send(es_bus(5'b10010, 8'h0C, 1'b0, 1'b0, 3'd0, 2'd0, 4'hF, 5'd3, 32'h1234_5678, pc));
        pc = pc + 32'd4;
        chk("alu_valid", ms_to_ws_valid, 1'b1);
        chk("alu_fwd", forward_ms_bus, {1'b1, 32'h1234_5678});
        chk("alu_stall", stall_ms_bus, {1'b1, 4'hF, 5'd3});
        tick();
        chk("alu_gone", ms_to_ws_valid, 1'b0);

        // Load flavours and byte-lane boundaries.
        load("lb",    3'd1, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 4'hF, 2);
        load("lbu",   3'd2, 2'd2, 32'h0080_0000, 32'h0000_0080, 4'hF, 0);
        load("lh",    3'd3, 2'd2, 32'h8001_1234, 32'hFFFF_8001, 4'hF, 1);
        load("lhu",   3'd4, 2'd0, 32'h1234_F00D, 32'h0000_F00D, 4'hF, 0);
        load("lw",    3'd0, 2'd0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'hF, 0);
        load("lwl1",  3'd5, 2'd1, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100, 0);
        load("lwl3",  3'd5, 2'd3, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111, 0);
        load("lwr2",  3'd6, 2'd2, 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011, 1);
        load("lwr0",  3'd6, 2'd0, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111, 0);
        load("type7", 3'd7, 2'd0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 4'hF, 0);

        // Store: waits for data_ok, writes no register lanes.
        exp_q.push_back(ws_bus(5'd0, 8'd0, 4'h0, 5'd8, 32'h0000_0200, pc));
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b0, 3'd0, 2'd0, 4'hF, 5'd8, 32'h0000_0200, pc));
        pc = pc + 32'd4;
        chk("st_stall", ms_allowin, 1'b0);
        chk("st_stall_v", stall_ms_bus[9], 1'b0);
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        #1;
        chk("st_valid", ms_to_ws_valid, 1'b1);
        tick();
        data_data_ok = 1'b0;

        // Flush while a load waits: its late response must not retire the next load.
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd9, 32'h0, pc));
        pc = pc + 32'd4;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", ms_to_ws_valid, 1'b0);
        chk("fl_allowin", ms_allowin, 1'b1);
        exp_q.push_back(ws_bus(5'd0, 8'd0, 4'hF, 5'd10, 32'h2222_2222, pc));
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd10, 32'h0, pc));
        pc = pc + 32'd4;
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        #1;
        chk("cancel_drop", ms_to_ws_valid, 1'b0);
        chk("cancel_stall", ms_allowin, 1'b0);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("cancel_wait", ms_to_ws_valid, 1'b0);
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h2222_2222;
        #1;
        chk("cancel_second", ms_to_ws_valid, 1'b1);
        tick();
        data_data_ok = 1'b0;

        // data_ok together with flush is consumed by the flushed load.
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd9, 32'h0, pc));
        pc = pc + 32'd4;
        flush        = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h3333_3333;
        tick();
        flush        = 1'b0;
        data_data_ok = 1'b0;
        load("no_cancel", 3'd0, 2'd0, 32'h4444_4444, 32'h4444_4444, 4'hF, 0);

        // Flush while ES offers a load: its request is owed a response to drop.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd12, 32'h0, pc);
        flush          = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        flush          = 1'b0;
        #1;
        chk("fles_valid", ms_to_ws_valid, 1'b0);
        chk("fles_allowin", ms_allowin, 1'b1);
        exp_q.push_back(ws_bus(5'd0, 8'd0, 4'hF, 5'd13, 32'h6666_6666, pc));
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd13, 32'h0, pc));
        pc = pc + 32'd4;
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        #1;
        chk("fles_drop", ms_to_ws_valid, 1'b0);
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h6666_6666;
        #1;
        chk("fles_second", ms_to_ws_valid, 1'b1);
        tick();
        data_data_ok = 1'b0;

        // Response while WB stalls is buffered and held stable.
        exp_q.push_back(ws_bus(5'd0, 8'd0, 4'hF, 5'd11, 32'hDEAD_BEEF, pc));
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd11, 32'h0, pc));
        pc = pc + 32'd4;
        ws_allowin   = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("buf_valid", ms_to_ws_valid, 1'b1);
        chk("buf_allowin", ms_allowin, 1'b0);
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0BAD_F00D;
        #1;
        chk("buf_hold_v", ms_to_ws_valid, 1'b1);
        chk("buf_hold_fwd", forward_ms_bus, {1'b1, 32'hDEAD_BEEF});
        tick();
        chk("buf_hold_fwd2", forward_ms_bus, {1'b1, 32'hDEAD_BEEF});
        ws_allowin = 1'b1;
        #1;
        chk("buf_allowin_rise", ms_allowin, 1'b1);
        tick();
        chk("buf_gone", ms_to_ws_valid, 1'b0);

        // Reset in the middle of a wait clears the stage and the cancel state.
        send(es_bus(5'd0, 8'd0, 1'b1, 1'b1, 3'd0, 2'd0, 4'hF, 5'd14, 32'h0, pc));
        pc = pc + 32'd4;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("mrst_allowin", ms_allowin, 1'b1);
        chk("mrst_valid", ms_to_ws_valid, 1'b0);
        chk("mrst_stall_v", stall_ms_bus[9], 1'b0);
        load("after_rst", 3'd0, 2'd0, 32'h7777_7777, 32'h7777_7777, 4'hF, 0);

        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and `wb_stage`. It latches the execute-stage bus and waits for the data-SRAM response when the instruction issued a data request. It extracts and aligns load data, including byte-lane write enables for `lwl`/`lwr`, and forwards the `MS_TO_WS_BUS` word to write-back. On a write-back flush it discards any in-flight data response so that response cannot retire against a later instruction.

## Interface
- `ES_TO_MS_BUS_WD`, 125, fields MSB to LSB:
  - bd[124], exc_sys[123], eret[122], cp0_wen[121], res_from_cp0[120], cp0_addr[119:112]
  - mem_req[111], load_op[110], load_type[109:107], addr_low[106:105], unused[104:73]
  - gr_we[72:69], dest[68:64], alu_result[63:32], pc[31:0]
- `MS_TO_WS_BUS_WD`, 86, layout exactly as consumed by `wb_stage`: bd, exc_sys, eret, cp0_wen, res_from_cp0, cp0_addr[8], gr_we[4], dest[5], final_result[32], pc[32].
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `resetn` in 1: synchronous, active-low reset.
  - `flush` in 1: exception/eret flush from WB.
  - `ms_allowin` out 1: MS can accept from ES this cycle.
  - `es_to_ms_valid` in 1: ES holds a valid instruction.
  - `es_to_ms_bus` in 125: ES payload.
  - `ws_allowin` in 1: WB can accept.
  - `ms_to_ws_valid` out 1: MS presents a valid instruction.
  - `ms_to_ws_bus` out 86: MS payload to WB.
  - `data_data_ok` in 1: one data-SRAM response, in request order.
  - `data_rdata` in 32: response data, valid with `data_data_ok`.
  - `stall_ms_bus` out 10: {ms_valid && |gr_we, masked gr_we[4], dest[5]}.
  - `forward_ms_bus` out 33: {ms_valid && ms_ready_go, final_result}.

## Operation
- Registers: `ms_valid`, `es_to_ms_bus_r` (125), `buf_valid`, `buf_data` (32), `cancel`.
- `ms_ready_go` = !mem_req || (data_data_ok && !cancel) || buf_valid.
- `ms_allowin` = !ms_valid || (ms_ready_go && ws_allowin).
- `ms_to_ws_valid` = ms_valid && ms_ready_go.
- Load word `ld` = buf_valid ? buf_data : data_rdata. Byte select = addr_low.
- final_result and gr_we by load_type when load_op is set:
  - 0 lw: ld, 1111.
  - 1 lb / 2 lbu: selected byte, sign-/zero-extended to 32.
  - 3 lh / 4 lhu: half selected by addr_low[1], sign-/zero-extended.
  - 5 lwl: ld << 8*(3-a); gr_we 1000 / 1100 / 1110 / 1111 for a = 0..3.
  - 6 lwr: ld >> 8*a; gr_we 1111 / 0111 / 0011 / 0001 for a = 0..3.
  - 7: reserved, treated as lw.
  - non-load: alu_result, bus gr_we unchanged.
- Store (mem_req && !load_op): waits for data_ok, then final_result = alu_result, gr_we = 0000.
- Response buffering: data_data_ok && !cancel && ms_valid && mem_req && !buf_valid && !ws_allowin → buf_valid=1, buf_data=data_rdata. buf_valid clears on MS→WS transfer.
- Cancel:
  - Set on flush when ms_valid && mem_req && !buf_valid && !data_data_ok.
  - Also set on flush when an ES instruction with mem_req=1 would have been latched that cycle.
  - While set, the next data_data_ok is dropped and clears `cancel`.
  - ES guarantees at most one outstanding request beyond the cancelled one, so one bit suffices.
- Flush: ms_valid←0, buf_valid←0; the ES instruction offered that cycle is not latched.
- Bus latch: es_to_ms_bus_r loads when es_to_ms_valid && ms_allowin && !flush.
- Priority: reset > flush > normal update.

## Timing
- Reset values: ms_valid=0, buf_valid=0, cancel=0. Hence ms_allowin=1, ms_to_ws_valid=0, stall_ms_bus[9]=0, forward_ms_bus[32]=0.
- Minimum latency is one cycle in MS. An instruction with no memory access, or whose data_ok arrives in its first MS cycle, leaves on the next edge.
- ms_to_ws_bus, stall and forward buses are combinational from the registers plus data_rdata/data_data_ok. Forward valid asserts only once load data is present.
- data_ok on the same cycle as flush belongs to the flushed instruction: consumed, cancel not set.
- data_ok while cancel=1 on the same cycle as a new MS instruction's wait: the response is dropped and the instruction keeps waiting.
- ws_allowin low with buffered data: output held stable until transfer.

## Test plan
- ALU op, alu_result=0x1234_5678, gr_we=1111 → ms_to_ws_valid one cycle after entry; final_result 0x1234_5678.
- lb addr_low=2, data_ok with rdata 0x00_80_00_00 two cycles late → MS stalls (ms_allowin=0); result 0xFFFF_FF80; lbu gives 0x0000_0080.
- lwl a=1, rdata 0xAABB_CCDD → result 0xCCDD_0000, gr_we 1100. lwr a=2 → result 0x0000_AABB, gr_we 0011.
- Load waiting, flush asserted, then data_ok 3 cycles later while a new load waits → first data_ok dropped; new load retires only on the second data_ok.
- data_ok while ws_allowin=0 with rdata 0xDEAD_BEEF, rdata changes next cycle, ws_allowin rises → WB receives 0xDEAD_BEEF.
- resetn low mid-wait → ms_valid=0, cancel=0, ms_allowin=1 on the next edge.
